// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock monitor: FSM state encoding and lock threshold.
package clk_mon_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] STALL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_MEASURE = MEASURE,
        S_STALL   = STALL
    } state_t;

    localparam logic [1:0] LOCK_COUNT = 2'd3;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous slow input plus rising-edge detect.
module edge_sync (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic d_async,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain and previous-value register
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_async;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow-clock monitor: one-cycle tick per input rising edge, period measurement,
// tolerance check, stall detection and lock status, all in the clk_100MHz domain.
module slow_clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned PERIOD_NOM = 100_000_000,
    parameter int unsigned TOL        = 1_000_000,
    parameter int unsigned TIMEOUT    = 200_000_000,
    parameter int unsigned CNT_W      = 28
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             clk_slow_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             stalled,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    // One extra bit so PERIOD_NOM+TOL cannot wrap against a CNT_W-bit period.
    localparam logic [CNT_W:0] RANGE_LO =
        (PERIOD_NOM > TOL) ? (CNT_W+1)'(PERIOD_NOM - TOL) : (CNT_W+1)'(0);
    localparam logic [CNT_W:0] RANGE_HI = (CNT_W+1)'(PERIOD_NOM + TOL);

    logic             rise_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       good_q, good_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             in_range_q, in_range_d;
    logic             stalled_q, stalled_d;
    logic             locked_q, locked_d;

    logic [CNT_W-1:0] period_meas_s;
    logic             hit_s;
    logic [1:0]       good_inc_s;
    logic [1:0]       good_next_s;

    edge_sync u_edge_sync (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .d_async    (clk_slow_in),
        .rise       (rise_s)
    );

    assign period_meas_s = cnt_q + CNT_ONE;
    assign hit_s         = ({1'b0, period_meas_s} >= RANGE_LO) &&
                           ({1'b0, period_meas_s} <= RANGE_HI);
    assign good_inc_s    = (good_q == LOCK_COUNT) ? good_q : good_q + 2'd1;
    assign good_next_s   = hit_s ? good_inc_s : 2'd0;

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        good_d     = good_q;
        tick_d     = 1'b0;
        period_d   = period_q;
        pvalid_d   = 1'b0;
        in_range_d = in_range_q;
        stalled_d  = stalled_q;
        locked_d   = locked_q;
        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    tick_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = S_MEASURE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEASURE: begin
                // An edge takes priority over a timeout in the same cycle.
                if (rise_s) begin
                    tick_d     = 1'b1;
                    period_d   = period_meas_s;
                    pvalid_d   = 1'b1;
                    in_range_d = hit_s;
                    cnt_d      = CNT_ZERO;
                    good_d     = good_next_s;
                    locked_d   = (good_next_s == LOCK_COUNT);
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = S_STALL;
                    stalled_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = 2'd0;
                    cnt_d     = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STALL: begin
                if (rise_s) begin
                    tick_d    = 1'b1;
                    stalled_d = 1'b0;
                    cnt_d     = CNT_ZERO;
                    state_d   = S_MEASURE;
                end else begin
                    state_d = S_STALL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            good_q     <= 2'd0;
            tick_q     <= 1'b0;
            period_q   <= CNT_ZERO;
            pvalid_q   <= 1'b0;
            in_range_q <= 1'b0;
            stalled_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_q     <= good_d;
            tick_q     <= tick_d;
            period_q   <= period_d;
            pvalid_q   <= pvalid_d;
            in_range_q <= in_range_d;
            stalled_q  <= stalled_d;
            locked_q   <= locked_d;
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign in_range     = in_range_q;
    assign stalled      = stalled_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Scoreboard bench for slow_clk_monitor with a small period/lock reference model.
module tb_slow_clk_monitor;

    localparam int PERIOD_NOM = 100;
    localparam int TOL        = 5;
    localparam int TIMEOUT    = 200;
    localparam int CNT_W      = 9;

    logic             clk_100MHz = 1'b0;
    logic             reset_n    = 1'b0;
    logic             clk_slow_in = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             stalled;
    logic             locked;

    typedef struct {
        int p;
        bit in_r;
        bit lk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   tick_total = 0;
    int   last_tick_cyc = 0;
    int   last_gap   = 0;
    int   model_good = 0;
    bit   sb_off     = 1'b0;
    bit   prev_tick  = 1'b0;
    bit   prev_valid = 1'b0;

    slow_clk_monitor #(
        .PERIOD_NOM (PERIOD_NOM),
        .TOL        (TOL),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_n      (reset_n),
        .clk_slow_in  (clk_slow_in),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .in_range     (in_range),
        .stalled      (stalled),
        .locked       (locked)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_expect(input int p);
        exp_t e;
        e.p    = p;
        e.in_r = (p >= PERIOD_NOM - TOL) && (p <= PERIOD_NOM + TOL);
        if (e.in_r) model_good = (model_good >= 3) ? 3 : model_good + 1;
        else        model_good = 0;
        e.lk = (model_good == 3);
        sb_q.push_back(e);
    endtask

    // One slow-clock cycle: rise now, fall after 'high', next rise after 'low'.
    task automatic slow_edge(input bit first, input int high, input int low);
        if (!first) push_expect(last_gap);
        clk_slow_in = 1'b1;
        repeat (high) @(negedge clk_100MHz);
        clk_slow_in = 1'b0;
        repeat (low) @(negedge clk_100MHz);
        last_gap = high + low;
    endtask

    task automatic do_reset();
        check("sb_drained", sb_q.size(), 0);
        @(negedge clk_100MHz);
        reset_n     = 1'b0;
        clk_slow_in = 1'b0;
        @(negedge clk_100MHz);
        check("rst_tick", tick, 0);
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_in_range", in_range, 0);
        check("rst_stalled", stalled, 0);
        check("rst_locked", locked, 0);
        @(negedge clk_100MHz);
        reset_n    = 1'b1;
        model_good = 0;
    endtask

    always @(negedge clk_100MHz) begin
        exp_t e;
        if (tick) begin
            check("tick_width", prev_tick, 0);
            tick_total++;
            last_tick_cyc = cyc;
        end
        if (period_valid) begin
            check("valid_width", prev_valid, 0);
            if (!sb_off) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check("period", period, e.p);
                    check("in_range", in_range, e.in_r);
                    check("locked_at_valid", locked, e.lk);
                end
            end
        end
        prev_tick  = tick;
        prev_valid = period_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int c0;
        int stall_cyc;

        do_reset();

        // Square wave, period 100, four edges.
        t0 = tick_total;
        slow_edge(1'b1, 50, 50);
        repeat (3) slow_edge(1'b0, 50, 50);
        check("sq_ticks", tick_total - t0, 4);
        check("sq_locked", locked, 1);
        do_reset();

        // Periods 100, 100, 120, then 100: lock must not appear.
        slow_edge(1'b1, 50, 50);
        slow_edge(1'b0, 50, 50);
        slow_edge(1'b0, 60, 60);
        slow_edge(1'b0, 50, 50);
        check("oor_locked", locked, 0);
        slow_edge(1'b0, 50, 50);
        check("oor_locked_after", locked, 0);
        do_reset();

        // Lock, then stall, then recovery edge.
        slow_edge(1'b1, 50, 50);
        repeat (2) slow_edge(1'b0, 50, 50);
        slow_edge(1'b0, 50, 0);
        check("pre_stall_locked", locked, 1);
        for (int i = 0; i < 400 && !stalled; i++) @(negedge clk_100MHz);
        stall_cyc = cyc;
        check("stall_seen", stalled, 1);
        check("stall_delay", stall_cyc - last_tick_cyc, TIMEOUT);
        check("stall_locked", locked, 0);
        model_good = 0;
        t0 = tick_total;
        slow_edge(1'b1, 50, 50);
        check("recover_tick", tick_total - t0, 1);
        check("recover_stalled", stalled, 0);
        do_reset();

        // Edge exactly at cnt == TIMEOUT-1.
        slow_edge(1'b1, 100, 100);
        slow_edge(1'b0, 50, 20);
        check("edge_at_timeout_stalled", stalled, 0);
        do_reset();

        // Reset mid-period after lock, then re-measure.
        slow_edge(1'b1, 50, 50);
        repeat (3) slow_edge(1'b0, 50, 50);
        slow_edge(1'b0, 50, 30);
        check("mid_locked", locked, 1);
        do_reset();
        slow_edge(1'b1, 50, 50);
        slow_edge(1'b0, 50, 50);
        check("post_rst_stalled", stalled, 0);
        do_reset();

        // Latency and short-pulse behaviour.
        @(negedge clk_100MHz);
        #1;
        clk_slow_in = 1'b1;
        c0 = cyc;
        t0 = tick_total;
        for (int i = 0; i < 10 && tick_total == t0; i++) begin
            @(negedge clk_100MHz);
            #1;
        end
        check("latency_tick", tick_total - t0, 1);
        check("latency", last_tick_cyc - c0, 3);
        repeat (5) @(negedge clk_100MHz);
        clk_slow_in = 1'b0;
        repeat (10) @(negedge clk_100MHz);
        sb_off = 1'b1;
        t0 = tick_total;
        clk_slow_in = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        clk_slow_in = 1'b0;
        repeat (20) @(negedge clk_100MHz);
        check("short_pulse_ticks", (tick_total - t0) <= 1, 1);
        sb_off = 1'b0;
        do_reset();

        repeat (5) @(negedge clk_100MHz);
        check("sb_final", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
